// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, reads a zero-latency instruction
// memory, and queues {pc, instr} pairs in a 2-entry buffer for decode.
//
// Decode handshake: if_valid/if_instr/if_pc describe the buffer head; the
// head is consumed on a rising edge where if_valid && if_ready are both high,
// and the head stays stable until it is consumed or flushed by a redirect.
module imem_fetch_ctrl #(
  parameter int          ADDR_WIDTH = 5,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_data,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [31:0]           if_instr,
  output logic [31:0]           if_pc,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  running,
  output logic                  fault,
  output logic [31:0]           fault_pc,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] buf0_pc_q, buf0_pc_d, buf0_instr_q, buf0_instr_d;
  logic [31:0] buf1_pc_q, buf1_pc_d, buf1_instr_q, buf1_instr_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  logic        pop;
  logic        fetch;
  logic        redirect;
  logic [1:0]  fill;

  assign imem_addr = pc_q[ADDR_WIDTH+1:2];
  assign if_valid  = (count_q != 2'd0);
  assign if_instr  = if_valid ? buf0_instr_q : 32'h0;
  assign if_pc     = if_valid ? buf0_pc_q : 32'h0;
  assign running   = (state_q == ST_RUN);
  assign fault     = fault_q;
  assign fault_pc  = fault_pc_q;
  assign state_dbg = state_q;

  // A redirect is only honoured outside FAULT; it then overrides push and pop.
  assign redirect = redirect_valid && (state_q != ST_FAULT);
  assign pop      = if_valid && if_ready;
  assign fetch    = (state_q == ST_RUN) && ((count_q != 2'd2) || pop);

  // Next-state: FSM, PC, fetch buffer shift/fill and fault capture.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    count_d      = count_q;
    buf0_pc_d    = buf0_pc_q;
    buf0_instr_d = buf0_instr_q;
    buf1_pc_d    = buf1_pc_q;
    buf1_instr_d = buf1_instr_q;
    fault_d      = fault_q;
    fault_pc_d   = fault_pc_q;
    fill         = count_q;

    if (redirect) begin
      count_d = 2'd0;
      if (redirect_pc[1:0] == 2'b00) begin
        pc_d = redirect_pc;
        if ((state_q == ST_RUN) && halt) begin
          state_d = ST_IDLE;
        end
      end else begin
        state_d    = ST_FAULT;
        fault_d    = 1'b1;
        fault_pc_d = redirect_pc;
      end
    end else begin
      // Pop shifts entry 1 into the head slot before any new push lands.
      if (pop) begin
        buf0_pc_d    = buf1_pc_q;
        buf0_instr_d = buf1_instr_q;
        fill         = count_q - 2'd1;
      end
      if (fetch) begin
        if (fill == 2'd0) begin
          buf0_pc_d    = pc_q;
          buf0_instr_d = imem_data;
        end else begin
          buf1_pc_d    = pc_q;
          buf1_instr_d = imem_data;
        end
        fill = fill + 2'd1;
        pc_d = pc_q + 32'd4;
      end
      count_d = fill;

      case (state_q)
        ST_IDLE:  if (start && !halt) state_d = ST_RUN;
        ST_RUN:   if (halt) state_d = ST_IDLE;
        default:  state_d = ST_FAULT;
      endcase
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      count_q      <= 2'd0;
      buf0_pc_q    <= 32'h0;
      buf0_instr_q <= 32'h0;
      buf1_pc_q    <= 32'h0;
      buf1_instr_q <= 32'h0;
      fault_q      <= 1'b0;
      fault_pc_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      count_q      <= count_d;
      buf0_pc_q    <= buf0_pc_d;
      buf0_instr_q <= buf0_instr_d;
      buf1_pc_q    <= buf1_pc_d;
      buf1_instr_q <= buf1_instr_d;
      fault_q      <= fault_d;
      fault_pc_q   <= fault_pc_d;
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a scoreboard queue holds the expected
// {pc, instr} stream, consumed whenever decode accepts the buffer head.
module tb_imem_fetch_ctrl;

  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          start;
  logic          halt;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          if_valid;
  logic          if_ready;
  logic [31:0]   if_instr;
  logic [31:0]   if_pc;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          running;
  logic          fault;
  logic [31:0]   fault_pc;
  logic [1:0]    state_dbg;

  logic [31:0]   mem [32];
  logic [63:0]   exp_q [$];
  int            n_checks;
  int            n_fail;

  imem_fetch_ctrl #(.ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .halt           (halt),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .running        (running),
    .fault          (fault),
    .fault_pc       (fault_pc),
    .state_dbg      (state_dbg)
  );

  // Clock and instruction memory model.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + i;
  end
  assign imem_data = mem[imem_addr];

  // Expected fetch pair for a byte pc under the bench memory image.
  function automatic logic [63:0] pair(input logic [31:0] p);
    logic [31:0] ins;
    ins = 32'h1000_0000 + {27'd0, p[6:2]};
    return {p, ins};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_run(input logic [31:0] first_pc, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(pair(first_pc + 32'd4 * i));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: a head accepted by decode must match the next expected pair.
  always @(negedge clk) begin
    if (if_valid && if_ready && !redirect_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL pop_underflow: observed pc %0h with no expected entry", if_pc);
      end else begin
        check("pop_stream", {if_pc, if_instr}, exp_q.pop_front());
      end
    end
  end

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    start          = 1'b0;
    halt           = 1'b0;
    if_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #12;
    check("rst_if_valid", if_valid, 0);
    check("rst_running", running, 0);
    check("rst_fault", fault, 0);
    check("rst_fault_pc", fault_pc, 0);
    check("rst_if_pc", if_pc, 0);
    check("rst_if_instr", if_instr, 0);
    check("rst_imem_addr", imem_addr, 0);
    rst = 1'b0;
    step();

    // Reset/start: one instruction per cycle, first push one edge after start.
    push_run(32'h0, 4);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_running", running, 1);
    check("start_no_valid_yet", if_valid, 0);
    step();
    check("first_valid", if_valid, 1);
    check("first_pc", {if_pc, if_instr}, pair(32'h0));
    repeat (4) step();

    // Aligned redirect to 0 with decode stalled, to restart the stream.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    if_ready       = 1'b0;
    step();
    redirect_valid = 1'b0;
    check("redir0_flush", if_valid, 0);
    check("redir0_addr", imem_addr, 0);

    // Backpressure: buffer fills to two, pc holds at 8, head stays at 0.
    push_run(32'h0, 4);
    repeat (5) step();
    check("bp_pc_hold", imem_addr, 2);
    check("bp_valid", if_valid, 1);
    check("bp_head", {if_pc, if_instr}, pair(32'h0));
    if_ready = 1'b1;
    repeat (4) step();
    if_ready = 1'b0;
    check("bp_resume_addr", imem_addr, 6);
    check("bp_sb_drained", exp_q.size(), 0);

    // Redirect to 0x40 while two entries are buffered.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    step();
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    check("redir_flush", if_valid, 0);
    check("redir_addr", imem_addr, 16);
    push_run(32'h40, 4);
    step();
    check("redir_head", {if_pc, if_instr}, 64'h0000_0040_1000_0010);

    // Halt for three cycles: last fetch happens, buffer drains, pc frozen.
    halt = 1'b1;
    repeat (3) step();
    check("halt_running", running, 0);
    check("halt_drained", if_valid, 0);
    check("halt_pc_frozen", imem_addr, 18);
    halt  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("resume_running", running, 1);
    step();
    check("resume_head", {if_pc, if_instr}, pair(32'h48));
    halt = 1'b1;
    step();
    start = 1'b1;
    step();
    check("start_halt_idle", running, 0);
    check("start_halt_state", state_dbg, 0);
    check("start_halt_addr", imem_addr, 20);
    start = 1'b0;
    halt  = 1'b0;
    step();
    check("halt_sb_drained", exp_q.size(), 0);

    // Misaligned redirect from RUN with two entries buffered.
    if_ready = 1'b0;
    start    = 1'b1;
    step();
    start = 1'b0;
    repeat (2) step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h42;
    step();
    redirect_valid = 1'b0;
    check("fault_flag", fault, 1);
    check("fault_pc", fault_pc, 32'h42);
    check("fault_valid", if_valid, 0);
    check("fault_running", running, 0);
    check("fault_state", state_dbg, 2);
    check("fault_pc_hold", imem_addr, 22);
    start          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h80;
    step();
    start          = 1'b0;
    redirect_valid = 1'b0;
    step();
    check("fault_sticky", fault, 1);
    check("fault_pc_sticky", fault_pc, 32'h42);
    check("fault_ignores_start", running, 0);
    check("fault_ignores_redir", imem_addr, 22);
    rst = 1'b1;
    #1;
    check("rst_clears_fault", fault, 0);
    check("rst_clears_fault_pc", fault_pc, 0);
    check("rst_clears_state", state_dbg, 0);
    check("rst_clears_pc", imem_addr, 0);
    #2;
    rst = 1'b0;
    step();

    // Asynchronous reset mid-RUN with pc at 0x1C.
    if_ready = 1'b1;
    push_run(32'h0, 6);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (7) step();
    check("pre_rst_addr", imem_addr, 7);
    check("pre_rst_head", {if_pc, if_instr}, pair(32'h18));
    rst = 1'b1;
    #1;
    check("async_rst_valid", if_valid, 0);
    check("async_rst_pc", imem_addr, 0);
    check("async_rst_running", running, 0);
    check("async_rst_if_pc", if_pc, 0);
    #2;
    rst = 1'b0;
    step();
    check("final_sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
Fetch sequencer for the combinational-read instruction memory. It owns the program counter and drives the word address to instruction memory each cycle. It captures {pc, instruction} pairs into a 2-entry fetch buffer and presents them to decode over a valid/ready handshake. It also handles start/halt control, branch/jump redirects with buffer flush, and a sticky fault on misaligned redirect targets.

Parameters:
ADDR_WIDTH, 5, instruction memory word-address width (2**ADDR_WIDTH words)
RESET_PC, 32'h0000_0000, byte address loaded into pc on reset (must be 4-byte aligned)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  pulse; IDLE -> RUN
halt  input  1  level; RUN -> IDLE
imem_addr  output  ADDR_WIDTH  word address to instruction memory, equals pc[ADDR_WIDTH+1:2]
imem_data  input  32  instruction word returned combinationally for imem_addr
if_valid  output  1  buffer head holds a valid instruction
if_ready  input  1  decode accepts head this cycle
if_instr  output  32  instruction at buffer head
if_pc  output  32  byte PC of instruction at buffer head
redirect_valid  input  1  pulse; control-flow change requested
redirect_pc  input  32  new byte PC
running  output  1  state == RUN
fault  output  1  sticky misaligned-redirect fault
fault_pc  output  32  offending redirect_pc captured on fault

Behaviour:
- Reset (async, takes effect immediately):
  - state = IDLE, pc = RESET_PC, buffer count = 0.
  - if_valid = 0, running = 0, fault = 0, fault_pc = 0.
  - if_instr and if_pc read 0 when the buffer is empty.
- imem_addr is purely combinational from pc. The instruction memory read is zero-latency, so the pair {pc, imem_data} is written into the buffer on the same edge it is fetched.
- Buffer:
  - 2-entry FIFO; head drives if_instr/if_pc.
  - if_valid = (count != 0).
  - pop = if_valid && if_ready.
- States: IDLE, RUN, FAULT.
- IDLE:
  - No fetch; pc holds.
  - Buffer still drains via pop.
  - start=1 -> RUN next cycle. If start and halt are both high, halt wins and the block stays IDLE.
- RUN:
  - fetch = (count < 2) || pop.
  - On fetch: push {pc, imem_data}; pc <= pc + 4.
  - Without fetch: pc holds.
  - Pop and push in the same cycle keep count unchanged.
  - halt=1 -> IDLE next cycle; the fetch in that cycle still happens.
  - Latency: start sampled at edge t, state RUN after t; first push at edge t+1; if_valid=1 after edge t+1.
- Redirect (redirect_valid=1, state IDLE or RUN):
  - Overrides fetch, push and pop for that cycle.
  - count <= 0; the imem_data fetched that cycle is discarded.
  - If redirect_pc[1:0] == 0: pc <= redirect_pc. State is unchanged, except halt in the same cycle still moves RUN -> IDLE.
  - If redirect_pc[1:0] != 0: state <= FAULT, fault <= 1, fault_pc <= redirect_pc, pc unchanged.
- FAULT:
  - No fetch; if_valid = 0; running = 0.
  - start, halt and redirect_valid are ignored.
  - Exit only via rst.
- Arithmetic: pc is 32-bit and wraps modulo 2^32. Addresses above memory size alias through imem_addr truncation; there is no fault for this.
- Handshake rule: once if_valid=1, if_instr/if_pc stay stable until pop or a redirect/fault flush.
- Reset mid-operation: immediate return to reset values. Any in-flight buffer contents are lost.

Test Plan:
- Reset/start: bench memory mem[i] = 32'h1000_0000 + i, RESET_PC=0, if_ready=1, start pulse -> from the 2nd cycle after start, if_pc = 0,4,8,... with if_instr = 32'h1000_0000, 32'h1000_0001, ... one per cycle.
- Backpressure: if_ready=0 for 5 cycles in RUN -> count saturates at 2, pc holds at 8, if_pc stays 0. Raise if_ready -> sequence 0,4,8,12 with no gaps or duplicates.
- Redirect: redirect_pc=32'h40 while 2 entries are buffered -> next cycle if_valid=0, imem_addr=16. The following cycle if_pc=32'h40, if_instr=32'h1000_0010.
- Misaligned: redirect_pc=32'h42 -> fault=1, fault_pc=32'h42, if_valid=0, running=0. A later start pulse leaves these unchanged; rst clears all.
- Halt/resume: halt for 3 cycles -> running=0, pc frozen, buffer drains to empty. Release halt, pulse start -> fetch resumes at the frozen pc. start+halt together -> stays IDLE.
- Async reset mid-RUN (asserted between clock edges, pc=32'h1C) -> if_valid=0 and pc=RESET_PC immediately, without waiting for a clock edge.
